// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction-memory loader.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  wren;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           din;
   logic                  core_hold;
   logic                  done;
   logic                  err;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, wren, addr, din, core_hold, done, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, wren, addr, din, core_hold, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream and writes 32-bit words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader #(
   parameter int         ADDR_WIDTH = 8,
   parameter logic [7:0] START_BYTE = 8'hA5
) (
   input  logic         clock,
   input  logic         clear,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, FINISH, FAIL} state_t;

   state_t                state_q, state_d;
   logic [8:0]            wcnt_q, wcnt_d;
   logic [1:0]            idx_q, idx_d;
   logic [23:0]           word_q, word_d;
   logic [7:0]            chk_q, chk_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           din_q, din_d;
   logic                  wren_q, wren_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  core_hold_q, core_hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  accept;

   assign accept = bus.rx_valid & rx_ready_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      word_d  = word_q;
      chk_d   = chk_q;
      addr_d  = addr_q;
      din_d   = din_q;
      wren_d  = 1'b0;

      // The address advances once the write using it has been presented.
      if (wren_q) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (accept && (bus.rx_data == START_BYTE)) begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (accept) begin
               wcnt_d  = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
               idx_d   = 2'd0;
               addr_d  = '0;
               chk_d   = 8'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               chk_d = chk_q ^ bus.rx_data;
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: word_d[7:0]   = bus.rx_data;
                  2'd1: word_d[15:8]  = bus.rx_data;
                  2'd2: word_d[23:16] = bus.rx_data;
                  default: begin
                     wren_d = 1'b1;
                     din_d  = {bus.rx_data, word_q};
                     wcnt_d = wcnt_q - 9'd1;
                     if (wcnt_q == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = FINISH;
`endif
                     end
                  end
               endcase
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) begin
               state_d = (bus.rx_data == chk_q) ? FINISH : FAIL;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      rx_ready_d  = !((state_d == FINISH) || (state_d == FAIL));
      core_hold_d = (state_d != IDLE) || wren_d;
      done_d      = (state_d == FINISH);
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_d       = (state_d == FAIL);
`else
      err_d       = 1'b0;
`endif
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= IDLE;
         wcnt_q      <= 9'd0;
         idx_q       <= 2'd0;
         word_q      <= 24'd0;
         chk_q       <= 8'd0;
         addr_q      <= '0;
         din_q       <= 32'd0;
         wren_q      <= 1'b0;
         rx_ready_q  <= 1'b1;
         core_hold_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (bus.rx_valid || (state_q != IDLE) || wren_q) begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         chk_q       <= chk_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         wren_q      <= wren_d;
         rx_ready_q  <= rx_ready_d;
         core_hold_q <= core_hold_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.wren      = wren_q;
   assign bus.addr      = addr_q;
   assign bus.din       = din_q;
   assign bus.core_hold = core_hold_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader; adapts to IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

   localparam int         ADDR_WIDTH = 8;
   localparam logic [7:0] START_BYTE = 8'hA5;

   logic clock;
   logic clear;
   int   testsRun;
   int   failCount;

   imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

   imem_loader #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .START_BYTE(START_BYTE)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [ADDR_WIDTH-1:0] logAddr[$];
   logic [31:0]           logDin[$];
   int                    doneCnt;
   int                    errCnt;
   int                    holdCnt;
   logic [31:0]           frameWords[256];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   always @(negedge clock) begin
      if (bus.wren) begin
         logAddr.push_back(bus.addr);
         logDin.push_back(bus.din);
         checkOutput("hold_at_wren", 32'(bus.core_hold), 32'd1);
      end
      if (bus.done) begin
         doneCnt++;
         checkOutput("ready_at_done", 32'(bus.rx_ready), 32'd0);
      end
      if (bus.err) errCnt++;
      if (bus.core_hold) holdCnt++;
   end

   task automatic clearLog();
      logAddr.delete();
      logDin.delete();
      doneCnt = 0;
      errCnt  = 0;
      holdCnt = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int waited;
      waited = 0;
      @(negedge clock);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && (waited < 20)) begin
         @(negedge clock);
         waited++;
      end
      if (!bus.rx_ready) begin
         checkOutput("rx_ready_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clock);
      end
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (gap) @(posedge clock);
   endtask

   task automatic sendFrame(input int n, input int gap, input logic [7:0] chkFlip);
      logic [7:0] chk;
      logic [7:0] b;
      logic [31:0] w;
      chk = 8'h00;
      applyStimulus(START_BYTE, gap);
      applyStimulus(n[7:0], gap);
      for (int i = 0; i < n; i++) begin
         w = frameWords[i];
         for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            chk = chk ^ b;
            applyStimulus(b, gap);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      applyStimulus(chk ^ chkFlip, gap);
`endif
      $display("[TB] frame of %0d words, checksum byte 0x%02h", n, chk ^ chkFlip);
      repeat (4) @(negedge clock);
   endtask

   task automatic checkFrame(input int n, input int expectDone, input int expectErr);
      int limit;
      checkOutput("wren_count", 32'(logAddr.size()), 32'(n));
      limit = (logAddr.size() < n) ? logAddr.size() : n;
      for (int i = 0; i < limit; i++) begin
         checkOutput("wren_addr", 32'(logAddr[i]), 32'(i % (1 << ADDR_WIDTH)));
         checkOutput("wren_din", logDin[i], frameWords[i]);
      end
      checkOutput("done_count", 32'(doneCnt), 32'(expectDone));
      checkOutput("err_count", 32'(errCnt), 32'(expectErr));
   endtask

   task automatic checkResetOutputs(input string prefix);
      checkOutput({prefix, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
      checkOutput({prefix, "_wren"}, 32'(bus.wren), 32'd0);
      checkOutput({prefix, "_addr"}, 32'(bus.addr), 32'd0);
      checkOutput({prefix, "_din"}, bus.din, 32'd0);
      checkOutput({prefix, "_core_hold"}, 32'(bus.core_hold), 32'd0);
      checkOutput({prefix, "_done"}, 32'(bus.done), 32'd0);
      checkOutput({prefix, "_err"}, 32'(bus.err), 32'd0);
   endtask

   initial begin
      testsRun     = 0;
      failCount    = 0;
      clear        = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      clearLog();

      repeat (3) @(negedge clock);
      checkResetOutputs("reset");
      clear = 1'b1;
      repeat (2) @(negedge clock);

      // Garbage bytes in IDLE are swallowed without holding the core.
      clearLog();
      applyStimulus(8'h00, 0);
      applyStimulus(8'hFF, 0);
      applyStimulus(8'h13, 0);
      repeat (3) @(negedge clock);
      checkOutput("idle_wren_count", 32'(logAddr.size()), 32'd0);
      checkOutput("idle_hold_cycles", 32'(holdCnt), 32'd0);
      checkOutput("idle_done", 32'(doneCnt), 32'd0);
      checkOutput("idle_err", 32'(errCnt), 32'd0);

      // Single-word frame (addi x0-style word).
      clearLog();
      frameWords[0] = 32'h00100013;
      sendFrame(1, 0, 8'h00);
      checkFrame(1, 1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Corrupted checksum: word still written, err instead of done.
      clearLog();
      frameWords[0] = 32'h00100013;
      sendFrame(1, 0, 8'h07);
      checkFrame(1, 0, 1);
`endif

      // Two words with three idle cycles between every byte.
      clearLog();
      frameWords[0] = 32'h00100093;
      frameWords[1] = 32'h00200113;
      sendFrame(2, 3, 8'h00);
      checkFrame(2, 1, 0);

      // Reset mid-frame discards the partial word.
      clearLog();
      applyStimulus(START_BYTE, 0);
      applyStimulus(8'h01, 0);
      applyStimulus(8'h13, 0);
      applyStimulus(8'h00, 0);
      @(negedge clock);
      clear = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clock);
      clear = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("midreset_wren_count", 32'(logAddr.size()), 32'd0);
      checkOutput("midreset_done", 32'(doneCnt), 32'd0);
      clearLog();
      frameWords[0] = 32'h00100013;
      sendFrame(1, 0, 8'h00);
      checkFrame(1, 1, 0);

      // Count byte 0 means 256 words, covering the full address range.
      clearLog();
      for (int i = 0; i < 256; i++) begin
         frameWords[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
      end
      sendFrame(256, 0, 8'h00);
      checkFrame(256, 1, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
